fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port stall, input, 1: decode not accepting; hold IF/ID.
REQ-005 SHALL have port flush, input, 1: kill IF/ID contents.
REQ-006 SHALL have port br_taken, input, 1: redirect PC this cycle.
REQ-007 SHALL have port br_target, input, 32: redirect address.
REQ-008 SHALL have port imem_req, output, 1: fetch request for imem_addr.
REQ-009 SHALL have port imem_addr, output, 32: current PC.
REQ-010 SHALL have port imem_ready, input, 1: imem_rdata valid for imem_addr this cycle.
REQ-011 SHALL have port imem_rdata, input, 32: fetched instruction.
REQ-012 SHALL have port id_valid, output, 1: IF/ID holds a live instruction.
REQ-013 SHALL have port id_instr, output, 32: IF/ID instruction.
REQ-014 SHALL have port id_pc, output, 32: address of id_instr.
REQ-015 SHALL have port id_pc4, output, 32: id_pc + 4, modulo 2^32.
REQ-016 SHALL have port id_imm16, output, 16: id_instr[15:0], driven to the decode sign extender.

Function
REQ-017 SHALL implement two states: FETCH (imem_req=1) and HOLD (imem_req=0, one instruction buffered internally).
REQ-018 SHALL drive imem_addr from the PC register at all times; imem_addr SHALL change only on a clock edge.
REQ-019 In FETCH with imem_ready=1, stall=0, br_taken=0: SHALL load IF/ID with imem_rdata/PC, set id_valid=1, PC <= PC+4, stay FETCH.
REQ-020 In FETCH with imem_ready=1, stall=1, br_taken=0: SHALL capture imem_rdata/PC in the hold buffer, PC <= PC+4, go HOLD; IF/ID unchanged.
REQ-021 In FETCH with imem_ready=0: SHALL keep PC; IF/ID SHALL load nothing; id_valid holds under stall, otherwise clears to 0 (bubble).
REQ-022 In HOLD with stall=0: SHALL move the buffer into IF/ID (id_valid=1), go FETCH; no fetch is issued that cycle.
REQ-023 In HOLD with stall=1: SHALL keep buffer, IF/ID and PC unchanged.
REQ-024 br_taken=1 in any state SHALL set PC <= {br_target[31:2],2'b00}, discard any same-cycle imem_rdata and the hold buffer, and go FETCH; imem SHALL restart on the new address.
REQ-025 flush=1 SHALL set id_valid=0 and id_instr=32'h0000_0000 (nop) at the next edge, overriding stall and any load into IF/ID.
REQ-026 flush=0, br_taken=1 SHALL still redirect PC; IF/ID follows stall rules but receives no instruction that cycle.
REQ-027 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
REQ-028 id_pc4 and id_imm16 SHALL be combinational from IF/ID registers; no extra latency.
REQ-029 Fetch-to-IF/ID latency SHALL be one edge after imem_ready when not stalled.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, set PC=RESET_PC, state FETCH, id_valid=0, id_instr=0, id_pc=0, buffer empty.
REQ-031 imem_req SHALL be 0 while rst=1 and 1 from the first edge after rst deasserts.
REQ-032 rst asserted mid-fetch or in HOLD SHALL discard the outstanding/buffered instruction.

Verification
REQ-033 Reset release, imem_ready=1 every cycle, rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8,...; id_pc trails by one edge; id_imm16=id_instr[15:0].
REQ-034 Ready with stall=1 at PC=8 for 3 cycles -> HOLD, imem_req=0, IF/ID keeps PC=4 entry; stall drop -> id_pc=8 next edge, then fetch of 12 resumes.
REQ-035 br_taken=1, br_target=32'h0000_0103 with imem_ready=1 -> same-cycle rdata dropped, next imem_addr=32'h0000_0100.
REQ-036 flush=1 with stall=1 and id_valid=1 -> id_valid=0, id_instr=0 next edge.
REQ-037 RESET_PC=32'hFFFF_FFF8, ready every cycle -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc4 of FFFF_FFFC entry = 0.
REQ-038 rst pulsed asynchronously between edges while in HOLD -> outputs reset immediately; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem request FSM with one-entry hold buffer, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [15:0] id_imm16
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      state_q, state_d;
  logic        started_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d, id_pc_q, id_pc_d;
  logic        fetch;
  // started_q keeps the request low until the first edge after reset release
  assign imem_req  = started_q && (state_q == FETCH);
  assign imem_addr = pc_q;
  assign fetch     = imem_req && imem_ready;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc_q + 32'd4;
  assign id_imm16  = id_instr_q[15:0];
  always_comb begin
    state_d     = state_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    pc_d        = br_taken ? (br_target & ~32'd3) : fetch ? pc_q + 32'd4 : pc_q;
    if (br_taken) state_d = FETCH;
    else if (state_q == FETCH && fetch && stall) begin
      state_d     = HOLD;
      buf_instr_d = imem_rdata;
      buf_pc_d    = pc_q;
    end else if (state_q == HOLD && !stall) state_d = FETCH;
    if (!stall) begin
      id_valid_d = 1'b0;
      if (!br_taken && state_q == FETCH && fetch) begin
        id_valid_d = 1'b1;
        id_instr_d = imem_rdata;
        id_pc_d    = pc_q;
      end else if (!br_taken && state_q == HOLD) begin
        id_valid_d = 1'b1;
        id_instr_d = buf_instr_q;
        id_pc_d    = buf_pc_q;
      end
    end
    if (flush) begin
      id_valid_d = 1'b0;
      id_instr_d = 32'h0000_0000;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      started_q   <= 1'b0;
      pc_q        <= RESET_PC;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'h0;
      id_pc_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      started_q   <= 1'b1;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed steps with a queue of expected decode-side instructions.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, br_taken, imem_ready;
  logic [31:0] br_target;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc4;
  logic [15:0] id_imm16;
  logic        imem_req1, id_valid1;
  logic [31:0] imem_addr1, id_instr1, id_pc1, id_pc41;
  logic [15:0] id_imm161;
  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4), .id_imm16(id_imm16));

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .br_taken(1'b0),
    .br_target(32'h0), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ready(1'b1), .imem_rdata(imem_addr1 ^ 32'hA5A5_0000), .id_valid(id_valid1),
    .id_instr(id_instr1), .id_pc(id_pc1), .id_pc4(id_pc41), .id_imm16(id_imm161));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [63:0] e;
    logic acc, take;
    acc  = imem_req && imem_ready && !br_taken && !flush;
    take = !stall && !flush;
    if (acc) q.push_back({imem_addr, imem_rdata});
    @(posedge clk);
    #1;
    if (take && id_valid) begin
      if (q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_pc", id_pc, e[63:32]);
        chk("sb_instr", id_instr, e[31:0]);
        chk("sb_pc4", id_pc4, e[63:32] + 32'd4);
        chk("sb_imm16", {16'h0, id_imm16}, {16'h0, e[15:0]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'h0; imem_ready = 1'b1;
    #2;
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_addr_wrap", imem_addr1, 32'hFFFF_FFF8);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("req_before_edge", {31'h0, imem_req}, 32'd0);
    tick();
    chk("req_after_edge", {31'h0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0);
    chk("bubble0", {31'h0, id_valid}, 32'd0);
    chk("wrap_addr0", imem_addr1, 32'hFFFF_FFF8);
    tick();
    chk("addr4", imem_addr, 32'h4);
    chk("idpc0", id_pc, 32'h0);
    chk("wrap_addr1", imem_addr1, 32'hFFFF_FFFC);
    chk("wrap_idpc1", id_pc1, 32'hFFFF_FFF8);
    tick();
    chk("addr8", imem_addr, 32'h8);
    chk("idpc4", id_pc, 32'h4);
    chk("wrap_addr2", imem_addr1, 32'h0000_0000);
    chk("wrap_idpc2", id_pc1, 32'hFFFF_FFFC);
    chk("wrap_idpc4", id_pc41, 32'h0000_0000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", {31'h0, imem_req}, 32'd0);
      chk("hold_idpc", id_pc, 32'h4);
      chk("hold_valid", {31'h0, id_valid}, 32'd1);
      chk("hold_addr", imem_addr, 32'hC);
    end
    stall = 1'b0;
    tick();
    chk("unhold_idpc", id_pc, 32'h8);
    chk("unhold_req", {31'h0, imem_req}, 32'd1);
    tick();
    chk("resume_idpc", id_pc, 32'hC);
    chk("resume_addr", imem_addr, 32'h10);
    imem_ready = 1'b0;
    tick();
    chk("notready_bubble", {31'h0, id_valid}, 32'd0);
    chk("notready_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; stall = 1'b1;
    tick();
    chk("notready_stall_valid", {31'h0, id_valid}, 32'd1);
    chk("notready_stall_pc", id_pc, 32'h10);
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'h0, id_valid}, 32'd0);
    chk("flush_instr", id_instr, 32'h0);
    flush = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    br_taken = 1'b1; br_target = 32'h0000_0103;
    tick();
    chk("br_addr", imem_addr, 32'h0000_0100);
    chk("br_drop", {31'h0, id_valid}, 32'd0);
    br_taken = 1'b0;
    tick();
    chk("br_idpc", id_pc, 32'h0000_0100);
    stall = 1'b1;
    tick();
    chk("pre_rst_hold", {31'h0, imem_req}, 32'd0);
    #3 rst = 1'b1;
    q.delete();
    #1;
    chk("async_req", {31'h0, imem_req}, 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_valid", {31'h0, id_valid}, 32'd0);
    chk("async_instr", id_instr, 32'h0);
    chk("async_pc", id_pc, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_req_low", {31'h0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("post_rst_req", {31'h0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_bubble", {31'h0, id_valid}, 32'd0);
    tick();
    chk("post_rst_idpc", id_pc, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
